// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : datapath_pkg
//  Purpose  : Shared sizes and index types for the DM-to-execute issue path.
//  Revision : 1.0  initial release
// ============================================================================
package datapath_pkg;

   localparam int REG_ADDRESS_SIZE = 5;
   localparam int ID_SIZE          = 2;
   localparam int DEPTH            = 2**ID_SIZE;
   localparam int NUM_REGS         = 2**REG_ADDRESS_SIZE;

   typedef logic [ID_SIZE-1:0]          rob_id_t;
   typedef logic [REG_ADDRESS_SIZE-1:0] reg_idx_t;
   typedef logic [ID_SIZE:0]            rob_cnt_t;

endpackage
`default_nettype wire

// File: rtl/rob_id_ring.sv
`default_nettype none
// ============================================================================
//  Module   : rob_id_ring
//  Purpose  : Circular ROB id allocator. Hands out ids at the tail, retires
//             them in order at the head, and flags out-of-order or empty
//             commits with a sticky error bit.
//  Revision : 1.0  initial release
// ============================================================================
module rob_id_ring
   import datapath_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     grant,
   input  logic     cmt_valid,
   input  rob_id_t  cmt_id,
   input  logic     flush,
   output rob_id_t  tail,
   output rob_cnt_t count,
   output logic     full,
   output logic     cmt_ok,
   output logic     cmt_error
);

   localparam rob_id_t  c_id_one  = 1;
   localparam rob_cnt_t c_cnt_one = 1;
   localparam rob_cnt_t c_depth   = rob_cnt_t'(DEPTH);

   rob_id_t  r_head;
   rob_id_t  r_tail;
   rob_cnt_t r_count;
   logic     r_cmt_error;
   logic     w_cmt_ok;
   rob_id_t  w_head_next;

   // A commit is honoured only when it retires the oldest live entry.
   assign w_cmt_ok    = cmt_valid & (cmt_id == r_head) & (r_count != '0);
   assign w_head_next = w_cmt_ok ? (r_head + c_id_one) : r_head;

   assign tail      = r_tail;
   assign count     = r_count;
   assign full      = (r_count == c_depth);
   assign cmt_ok    = w_cmt_ok;
   assign cmt_error = r_cmt_error;

   // Head/tail/count update; flush collapses the window onto the (new) head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_cmt_error <= 1'b0;
      end else begin
         if (cmt_valid && !w_cmt_ok)
            r_cmt_error <= 1'b1;
         r_head <= w_head_next;
         if (flush) begin
            r_tail  <= w_head_next;
            r_count <= '0;
         end else begin
            if (grant)
               r_tail <= r_tail + c_id_one;
            case ({grant, w_cmt_ok})
               2'b10:   r_count <= r_count + c_cnt_one;
               2'b01:   r_count <= r_count - c_cnt_one;
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard
//  Purpose  : In-order issue controller. Tracks busy destination registers,
//             stalls DM on RAW/WAW hazards or a full ROB window, releases
//             registers on commit and discards everything on flush.
//  Revision : 1.0  initial release
// ============================================================================
module issue_scoreboard
   import datapath_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     iss_valid,
   input  reg_idx_t iss_src1,
   input  reg_idx_t iss_src2,
   input  logic     iss_use_src2,
   input  reg_idx_t iss_dest,
   input  logic     iss_w,
   output logic     iss_stall,
   output logic     iss_grant,
   output rob_id_t  iss_id,
   input  logic     cmt_valid,
   input  rob_id_t  cmt_id,
   input  reg_idx_t cmt_dest,
   input  logic     cmt_w,
   input  logic     flush,
   output rob_cnt_t inflight,
   output logic     cmt_error
);

   logic [NUM_REGS-1:0] r_busy;
   rob_id_t             r_owner [NUM_REGS];

   rob_id_t  w_tail;
   rob_cnt_t w_count;
   logic     w_full;
   logic     w_cmt_ok;
   logic     w_hazard;
   logic     w_set;
   logic     w_clr;

   rob_id_ring u_ring (
      .clk       (clk),
      .reset     (reset),
      .grant     (iss_grant),
      .cmt_valid (cmt_valid),
      .cmt_id    (cmt_id),
      .flush     (flush),
      .tail      (w_tail),
      .count     (w_count),
      .full      (w_full),
      .cmt_ok    (w_cmt_ok),
      .cmt_error (cmt_error)
   );

   // r0 is never marked busy, so reads of r0 can never raise a hazard here.
   assign w_hazard  = r_busy[iss_src1]
                    | (iss_use_src2 & r_busy[iss_src2])
                    | (iss_w & r_busy[iss_dest])
                    | w_full
                    | flush;
   // Gated by reset so both handshake outputs read 0 while reset is held.
   assign iss_stall = reset & iss_valid & w_hazard;
   assign iss_grant = reset & iss_valid & ~w_hazard;
   assign iss_id    = w_tail;
   assign inflight  = w_count;

   assign w_set = iss_grant & iss_w & (iss_dest != '0);
   // Only the current owner may release a register; older writers are stale.
   assign w_clr = w_cmt_ok & cmt_w & r_busy[cmt_dest] & (r_owner[cmt_dest] == cmt_id);

   // Busy/owner table: clear on commit first so a same-cycle issue set wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            r_owner[i] <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         if (w_clr)
            r_busy[cmt_dest] <= 1'b0;
         if (w_set) begin
            r_busy[iss_dest]  <= 1'b1;
            r_owner[iss_dest] <= w_tail;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scoreboard
//  Purpose  : Directed and random checks of issue_scoreboard against a
//             queue-based model of the in-flight window.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_scoreboard;
   import datapath_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     iss_valid, iss_use_src2, iss_w;
   reg_idx_t iss_src1, iss_src2, iss_dest;
   logic     iss_stall, iss_grant;
   rob_id_t  iss_id;
   logic     cmt_valid, cmt_w, flush;
   rob_id_t  cmt_id;
   reg_idx_t cmt_dest;
   rob_cnt_t inflight;
   logic     cmt_error;

   always #5 clk = ~clk;

   issue_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .iss_valid    (iss_valid),
      .iss_src1     (iss_src1),
      .iss_src2     (iss_src2),
      .iss_use_src2 (iss_use_src2),
      .iss_dest     (iss_dest),
      .iss_w        (iss_w),
      .iss_stall    (iss_stall),
      .iss_grant    (iss_grant),
      .iss_id       (iss_id),
      .cmt_valid    (cmt_valid),
      .cmt_id       (cmt_id),
      .cmt_dest     (cmt_dest),
      .cmt_w        (cmt_w),
      .flush        (flush),
      .inflight     (inflight),
      .cmt_error    (cmt_error)
   );

   // Reference model: ordered list of live ROB entries plus a per-register
   // record of which id (if any) currently owns it.
   typedef struct {
      int id;
      int dest;
      bit w;
   } ent_t;

   ent_t q[$];
   int   m_head, m_tail;
   bit   m_err;
   int   owner_of [NUM_REGS];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic bit m_busy(int r);
      return owner_of[r] >= 0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      q.delete();
      m_head = 0;
      m_tail = 0;
      m_err  = 1'b0;
      foreach (owner_of[i]) owner_of[i] = -1;
   endtask

   task automatic drive(bit v, int s1, int s2, bit u2, int d, bit w,
                        bit cv, int cid, int cd, bit cw, bit fl);
      iss_valid    = v;
      iss_src1     = reg_idx_t'(s1);
      iss_src2     = reg_idx_t'(s2);
      iss_use_src2 = u2;
      iss_dest     = reg_idx_t'(d);
      iss_w        = w;
      cmt_valid    = cv;
      cmt_id       = rob_id_t'(cid);
      cmt_dest     = reg_idx_t'(cd);
      cmt_w        = cw;
      flush        = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Inputs are already driven (just after a falling edge). Check, clock, update.
   task automatic cycle(string tag);
      bit exp_stall, exp_grant, cok;
      #1;
      exp_stall = iss_valid && (m_busy(int'(iss_src1))
                  || (iss_use_src2 && m_busy(int'(iss_src2)))
                  || (iss_w && m_busy(int'(iss_dest)))
                  || (q.size() == DEPTH) || flush);
      exp_grant = iss_valid && !exp_stall;
      chk({tag, ".stall"},    32'(iss_stall), 32'(exp_stall));
      chk({tag, ".grant"},    32'(iss_grant), 32'(exp_grant));
      chk({tag, ".id"},       32'(iss_id),    m_tail);
      chk({tag, ".inflight"}, 32'(inflight),  q.size());
      chk({tag, ".cmt_err"},  32'(cmt_error), 32'(m_err));
      @(posedge clk);
      cok = cmt_valid && (q.size() > 0) && (int'(cmt_id) == m_head);
      if (cmt_valid && !cok) m_err = 1'b1;
      if (flush) begin
         if (cok) m_head = (m_head + 1) % DEPTH;
         q.delete();
         foreach (owner_of[i]) owner_of[i] = -1;
         m_tail = m_head;
      end else begin
         if (cok) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
            if (cmt_w && owner_of[cmt_dest] == int'(cmt_id))
               owner_of[cmt_dest] = -1;
         end
         if (exp_grant) begin
            q.push_back('{m_tail, int'(iss_dest), iss_w});
            if (iss_w && iss_dest != '0) owner_of[iss_dest] = m_tail;
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      m_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Reset state
      cycle("reset");

      // RAW on r3, release by commit, no bypass
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); cycle("t1.issue_r3");
      drive(1, 3, 0, 0, 4, 0, 0, 0, 0, 0, 0); cycle("t1.raw");
      drive(1, 3, 0, 0, 4, 0, 1, 0, 3, 1, 0); cycle("t1.raw_cmt");
      drive(1, 3, 0, 0, 4, 0, 0, 0, 0, 0, 0); cycle("t1.released");

      // Fill the window, id wrap, full stall, commit+issue together
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); cycle("t2.w7");
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0); cycle("t2.w8");
      drive(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0); cycle("t2.w9_wrap");
      drive(1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0); cycle("t2.full");
      drive(1, 0, 0, 0, 10, 1, 1, 1, 4, 0, 0); cycle("t2.full_cmt");
      drive(1, 0, 0, 0, 10, 1, 1, 2, 7, 1, 0); cycle("t2.cmt_iss");
      idle(); cycle("t2.idle");

      // Flush with three in flight, busy cleared, then flush with commit
      drive(1, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1); cycle("t4.flush");
      drive(1, 8, 9, 1, 11, 1, 0, 0, 0, 0, 0); cycle("t4.after_flush");
      drive(1, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0); cycle("t4.w12");
      drive(0, 0, 0, 0, 0, 0, 1, 3, 11, 1, 1); cycle("t4.flush_cmt");
      idle(); cycle("t4.idle");

      // WAW on r5, then a commit that does not own its register
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); cycle("t3.w5");
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); cycle("t3.waw");
      drive(1, 0, 0, 0, 5, 1, 1, 0, 5, 1, 0); cycle("t3.waw_cmt");
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); cycle("t3.waw_go");
      drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0); cycle("t3.w6");
      drive(0, 0, 0, 0, 0, 0, 1, 1, 6, 1, 0); cycle("t3.stale_cmt");
      drive(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("t3.r6_busy");
      drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle("t3.r5_busy");

      // Asynchronous reset mid-stream with busy registers
      drive(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0); cycle("t6.w9");
      drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3 reset = 1'b0;
      #1;
      chk("t6.rst.stall",    32'(iss_stall), 0);
      chk("t6.rst.grant",    32'(iss_grant), 0);
      chk("t6.rst.id",       32'(iss_id),    0);
      chk("t6.rst.inflight", 32'(inflight),  0);
      chk("t6.rst.cmt_err",  32'(cmt_error), 0);
      idle();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_reset();
      drive(1, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0); cycle("t6.r9_free_w0");
      drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); cycle("t6.r0_read");

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         bit cv, cw;
         int cid, cd;
         cv = 0; cw = 0; cid = 0; cd = 0;
         if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
            cv  = 1;
            cid = q[0].id;
            cd  = q[0].dest;
            cw  = q[0].w;
            if ($urandom_range(0, 39) == 0) cid = int'($urandom_range(0, 3));
         end
         drive($urandom_range(0, 9) < 7,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)),
               cv, cid, cd, cw, $urandom_range(0, 24) == 0);
         cycle("rnd");
      end

      // Commit errors: clean start, then empty commit and out-of-order commit
      idle();
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0); cycle("t5.empty_cmt");
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); cycle("t5.sticky_w3");
      drive(0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0); cycle("t5.bad_id");
      drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("t5.r3_still_busy");
      drive(0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0); cycle("t5.good_cmt");
      idle(); cycle("t5.final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
